// File: rtl/mc_cpu.sv
// Multi-cycle FETCH/EXEC/MEM accumulator-free RISC core with a split
// instruction/data memory handshake (req held until ack, any latency).
module mc_cpu #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int PC_W   = 12,
  localparam int INSTR_W = 4 + 3 * REG_AW
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [PC_W-1:0]    dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         status,
  output logic               retire,
  output logic               halted
);

  localparam int NREG = 2 ** REG_AW;
  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BNZ  = 4'hD;
  localparam logic [3:0] OP_BC   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [3:0]        flags;  // {N,V,C,Z}
  } alu_out_t;

  // Carry on SUB is the unsigned borrow, so it is set exactly when a < b.
  function automatic alu_out_t alu(input logic [3:0] op,
                                   input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b);
    alu_out_t          o;
    logic [DATA_W:0]   wide;
    logic              c;
    logic              v;
    o    = '0;
    wide = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        o.res = wide[DATA_W-1:0];
        c     = wide[DATA_W];
        v     = (a[DATA_W-1] == b[DATA_W-1]) && (o.res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        o.res = a - b;
        c     = $unsigned(a) < $unsigned(b);
        v     = (a[DATA_W-1] != b[DATA_W-1]) && (o.res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  o.res = a & b;
      OP_OR:   o.res = a | b;
      OP_XOR:  o.res = a ^ b;
      OP_SHL:  o.res = $unsigned(a) << b[SH_W-1:0];
      OP_SHR:  o.res = $unsigned(a) >> b[SH_W-1:0];
      default: o.res = '0;
    endcase
    o.flags = {o.res[DATA_W-1], v, c, (o.res == '0)};
    return o;
  endfunction

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [3:0]           status_q, status_d;
  logic [DATA_W-1:0]    regs_q [NREG];
  logic [DATA_W-1:0]    regs_d [NREG];

  logic                 rf_we;
  logic [DATA_W-1:0]    rf_wdata;

  logic [3:0]           op;
  logic [REG_AW-1:0]    s1, s2, d;
  logic signed [DATA_W-1:0] rs1_val, rs2_val;
  logic [DATA_W-1:0]    imm_val;
  logic [PC_W-1:0]      jmp_target;
  alu_out_t             alu_o;

  assign op = ir_q[INSTR_W-1 -: 4];
  assign s1 = ir_q[3*REG_AW-1 -: REG_AW];
  assign s2 = ir_q[2*REG_AW-1 -: REG_AW];
  assign d  = ir_q[REG_AW-1:0];

  assign rs1_val    = (s1 == '0) ? '0 : regs_q[s1];
  assign rs2_val    = (s2 == '0) ? '0 : regs_q[s2];
  assign imm_val    = DATA_W'({s2, s1});
  assign jmp_target = PC_W'({s1, s2, d});
  assign alu_o      = alu(op, rs1_val, rs2_val);

  assign imem_addr  = pc_q;
  assign dmem_addr  = PC_W'($unsigned(rs1_val));
  assign dmem_wdata = rs2_val;
  assign pc         = pc_q;
  assign status     = status_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    status_d = status_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        retire  = 1'b1;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            rf_we    = 1'b1;
            rf_wdata = alu_o.res;
            status_d = alu_o.flags;
          end
          OP_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = imm_val;
          end
          OP_LD, OP_ST: begin
            retire  = 1'b0;
            state_d = S_MEM;
          end
          OP_JMP: pc_d = jmp_target;
          OP_BZ:  if (status_q[0])  pc_d = jmp_target;
          OP_BNZ: if (!status_q[0]) pc_d = jmp_target;
          OP_BC:  if (status_q[1])  pc_d = jmp_target;
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_ST);
        if (dmem_ack) begin
          if (op == OP_LD) begin
            rf_we    = 1'b1;
            rf_wdata = dmem_rdata;
          end
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Reset silences the bus in the very cycle it is asserted.
    if (reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      retire   = 1'b0;
      halted   = 1'b0;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (rf_we && (d != '0)) regs_d[d] = rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      status_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      status_q <= status_d;
      regs_q   <= regs_d;
    end
  end

endmodule

// File: tb/tb_mc_cpu.sv
// Bench for mc_cpu: small programs run against behavioural instruction and
// data memories with programmable wait states; stores are scoreboarded.
module tb_mc_cpu;
  localparam int DATA_W  = 16;
  localparam int REG_AW  = 4;
  localparam int PC_W    = 12;
  localparam int INSTR_W = 4 + 3 * REG_AW;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               imem_req, imem_ack;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req, dmem_we, dmem_ack;
  logic [PC_W-1:0]    dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata, dmem_rdata;
  logic [PC_W-1:0]    pc;
  logic [3:0]         status;
  logic               retire, halted;

  always #5 clk = ~clk;

  mc_cpu #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .status(status), .retire(retire), .halted(halted)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory models with configurable wait states
  logic [INSTR_W-1:0] imem [0:4095];
  logic [DATA_W-1:0]  dmem [0:255];
  int   iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  logic force_iack = 1'b0;

  assign imem_ack   = (imem_req && (icnt >= iwait)) || force_iack;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt >= dwait);
  assign dmem_rdata = dmem[dmem_addr[7:0]];

  always @(posedge clk) begin
    if (reset || !imem_req || imem_ack) icnt <= 0; else icnt <= icnt + 1;
    if (reset || !dmem_req || dmem_ack) dcnt <= 0; else dcnt <= dcnt + 1;
    if (!reset && dmem_req && dmem_we && dmem_ack) dmem[dmem_addr[7:0]] <= dmem_wdata;
  end

  // Scoreboard of expected stores
  typedef struct {
    logic [PC_W-1:0]   addr;
    logic [DATA_W-1:0] data;
  } st_t;
  st_t exp_q[$];

  task automatic push_exp(input logic [PC_W-1:0] a, input logic [DATA_W-1:0] v);
    st_t s;
    s.addr = a;
    s.data = v;
    exp_q.push_back(s);
  endtask

  int retire_cnt = 0, cyc = 0, dlen = 0;
  int ret_cyc[$];
  int dlen_q[$];
  logic              stable = 1'b1, we0 = 1'b0;
  logic [PC_W-1:0]   a0 = '0;
  logic [DATA_W-1:0] w0 = '0;

  initial begin
    st_t s;
    forever begin
      @(negedge clk);
      if (reset) begin
        retire_cnt = 0;
        cyc = 0;
        dlen = 0;
        ret_cyc.delete();
      end else begin
        cyc++;
        if (imem_req || dmem_req) check("req_exclusive", imem_req && dmem_req, 0);
        if (halted) check("halt_no_req", imem_req || dmem_req, 0);
        if (retire) begin
          retire_cnt++;
          ret_cyc.push_back(cyc);
        end
        if (dmem_req) begin
          if (dlen == 0) begin
            a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we; stable = 1'b1;
          end else if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== we0) begin
            stable = 1'b0;
          end
          dlen++;
          if (dmem_ack) begin
            check("dmem_stable", stable, 1);
            dlen_q.push_back(dlen);
            dlen = 0;
            if (dmem_we) begin
              check("store_expected", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                check("store_addr", dmem_addr, s.addr);
                check("store_data", dmem_wdata, s.data);
              end
            end
          end
        end
      end
    end
  end

  // Program assembly helpers
  int pa = 0;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] s1,
                                      input logic [3:0] s2, input logic [3:0] d);
    return {op, s1, s2, d};
  endfunction

  task automatic emit(input logic [15:0] ins);
    imem[pa] = ins;
    pa++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) imem[i] = 16'hF000;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    pa = 0;
    exp_q.delete();
    dlen_q.delete();
  endtask

  // r = val using r14/r15 as scratch; the final OR leaves val's flags
  task automatic emit_const(input logic [3:0] r, input logic [15:0] val);
    emit(enc(4'h8, val[11:8], val[15:12], r));
    emit(enc(4'h8, 4'd8, 4'd0, 4'd15));
    emit(enc(4'h6, r, 4'd15, r));
    emit(enc(4'h8, val[3:0], val[7:4], 4'd14));
    emit(enc(4'h4, r, 4'd14, r));
  endtask

  task automatic start_cpu();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("reset_outputs", {imem_req, dmem_req, dmem_we, retire, halted}, 5'b0);
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_halt(input string nm, input int bound);
    int n = 0;
    while (!halted && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_halted"}, halted, 1);
  endtask

  task automatic finish_prog(input string nm, input int exp_ret, input logic [3:0] exp_st);
    check({nm, "_retires"}, retire_cnt, exp_ret);
    check({nm, "_status"}, status, exp_st);
    check({nm, "_sb_empty"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  st;
  } vec_t;
  localparam int NV = 14;
  vec_t vt[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    logic found;
    int exp_rc[4];
    string nm;

    vt[0]  = '{4'h1, 16'h0005, 16'h0003, 16'h0008, 4'h0};
    vt[1]  = '{4'h2, 16'h0001, 16'h0002, 16'hFFFF, 4'hA};
    vt[2]  = '{4'h1, 16'h7FFF, 16'h0001, 16'h8000, 4'hC};
    vt[3]  = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 4'h3};
    vt[4]  = '{4'h2, 16'h8000, 16'h0001, 16'h7FFF, 4'h4};
    vt[5]  = '{4'h2, 16'h0005, 16'h0005, 16'h0000, 4'h1};
    vt[6]  = '{4'h3, 16'hF0F0, 16'hFF00, 16'hF000, 4'h8};
    vt[7]  = '{4'h4, 16'h0F00, 16'h00F0, 16'h0FF0, 4'h0};
    vt[8]  = '{4'h5, 16'hAAAA, 16'hAAAA, 16'h0000, 4'h1};
    vt[9]  = '{4'h6, 16'h0001, 16'h0013, 16'h0008, 4'h0};
    vt[10] = '{4'h7, 16'h8000, 16'h000F, 16'h0001, 4'h0};
    vt[11] = '{4'h7, 16'hFFFF, 16'h0004, 16'h0FFF, 4'h0};
    vt[12] = '{4'h2, 16'h0003, 16'hFFFD, 16'h0006, 4'h2};
    vt[13] = '{4'h1, 16'h8000, 16'h8000, 16'h0000, 4'h7};

    // ALU vectors: r3 = r1 op r2, stored to [0]
    for (int i = 0; i < NV; i++) begin
      nm = $sformatf("vec%0d", i);
      clear_mem();
      emit_const(4'd1, vt[i].a);
      emit_const(4'd2, vt[i].b);
      emit(enc(vt[i].op, 4'd1, 4'd2, 4'd3));
      emit(enc(4'hA, 4'd0, 4'd3, 4'd0));
      emit(enc(4'hF, 4'd0, 4'd0, 4'd0));
      push_exp(12'h000, vt[i].res);
      iwait = $urandom_range(0, 2);
      dwait = $urandom_range(0, 2);
      start_cpu();
      wait_halt(nm, 500);
      finish_prog(nm, pa, vt[i].st);
    end

    // Zero-wait timing: LDI, LDI, ADD, ST, HALT
    clear_mem();
    emit(enc(4'h8, 4'd5, 4'd0, 4'd1));
    emit(enc(4'h8, 4'd3, 4'd0, 4'd2));
    emit(enc(4'h1, 4'd1, 4'd2, 4'd3));
    emit(enc(4'hA, 4'd0, 4'd3, 4'd0));
    emit(enc(4'hF, 4'd0, 4'd0, 4'd0));
    push_exp(12'h000, 16'h0008);
    iwait = 0;
    dwait = 0;
    start_cpu();
    @(negedge clk);
    check("first_fetch", {imem_req, imem_addr}, {1'b1, 12'h000});
    wait_halt("timing", 100);
    exp_rc = '{2, 4, 6, 9};
    for (int k = 0; k < 4; k++)
      check($sformatf("retire_cycle%0d", k), (k < ret_cyc.size()) ? ret_cyc[k] : -1, exp_rc[k]);
    finish_prog("timing", 5, 4'h0);

    // Branches on SUB flags: BZ not taken, BNZ taken, BC taken to 0x040
    clear_mem();
    emit(enc(4'h8, 4'd1, 4'd0, 4'd1));
    emit(enc(4'h8, 4'd2, 4'd0, 4'd2));
    emit(enc(4'h2, 4'd1, 4'd2, 4'd3));
    emit(enc(4'hC, 4'd0, 4'd8, 4'd0));
    emit(enc(4'hD, 4'd0, 4'd3, 4'd0));
    pa = 12'h030;
    emit(enc(4'hE, 4'd0, 4'd4, 4'd0));
    pa = 12'h040;
    emit(enc(4'hA, 4'd0, 4'd3, 4'd0));
    pa = 12'h080;
    emit(enc(4'hA, 4'd0, 4'd1, 4'd0));
    push_exp(12'h000, 16'hFFFF);
    start_cpu();
    wait_halt("branch", 200);
    finish_prog("branch", 8, 4'hA);
    check("branch_pc", pc, 12'h042);

    // r0 ignores LDI and ALU writes
    clear_mem();
    emit(enc(4'h8, 4'd5, 4'd5, 4'd0));
    emit(enc(4'h8, 4'hF, 4'h7, 4'd1));
    emit(enc(4'h1, 4'd1, 4'd1, 4'd0));
    emit(enc(4'hA, 4'd1, 4'd0, 4'd0));
    emit(enc(4'hF, 4'd0, 4'd0, 4'd0));
    push_exp(12'h07F, 16'h0000);
    iwait = 1;
    start_cpu();
    wait_halt("r0", 200);
    finish_prog("r0", 5, 4'h0);

    // Store then load with three data wait cycles
    clear_mem();
    emit_const(4'd1, 16'hBEEF);
    emit(enc(4'h8, 4'd0, 4'd1, 4'd2));
    emit(enc(4'hA, 4'd2, 4'd1, 4'd0));
    emit(enc(4'h9, 4'd2, 4'd0, 4'd4));
    emit(enc(4'hA, 4'd0, 4'd4, 4'd0));
    emit(enc(4'hF, 4'd0, 4'd0, 4'd0));
    push_exp(12'h010, 16'hBEEF);
    push_exp(12'h000, 16'hBEEF);
    iwait = 1;
    dwait = 3;
    start_cpu();
    wait_halt("ldst", 400);
    finish_prog("ldst", 10, 4'h8);
    check("ldst_txn_count", dlen_q.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("ldst_req_len%0d", k), (k < dlen_q.size()) ? dlen_q[k] : -1, 4);

    // PC wrap from 0xFFF, then HALT stays quiet
    clear_mem();
    emit(enc(4'hD, 4'd0, 4'd1, 4'd0));
    emit(enc(4'hF, 4'd0, 4'd0, 4'd0));
    pa = 12'h010;
    emit(enc(4'hB, 4'hF, 4'hF, 4'hF));
    pa = 12'hFFF;
    emit(enc(4'h4, 4'd0, 4'd0, 4'd5));
    iwait = 0;
    dwait = 0;
    start_cpu();
    n = 0;
    found = 1'b0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (imem_req && imem_ack && imem_addr == 12'hFFF) found = 1'b1;
    end
    check("fetch_fff_seen", found, 1);
    @(negedge clk);
    check("pc_wrap", pc, 12'h000);
    wait_halt("wrap", 200);
    finish_prog("wrap", 5, 4'h1);
    check("wrap_final_pc", pc, 12'h002);
    repeat (10) @(negedge clk);
    check("halt_sticky", halted, 1);

    // Reset during a stalled fetch, with a late ack inside reset
    clear_mem();
    emit(enc(4'h8, 4'd0, 4'd8, 4'd1));
    emit(enc(4'h8, 4'd8, 4'd0, 4'd15));
    emit(enc(4'h6, 4'd1, 4'd15, 4'd1));
    emit(enc(4'hA, 4'd0, 4'd1, 4'd0));
    emit(enc(4'hF, 4'd0, 4'd0, 4'd0));
    push_exp(12'h000, 16'h8000);
    iwait = 0;
    start_cpu();
    n = 0;
    cnt = 0;
    while (cnt < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (retire) cnt++;
    end
    check("pre_reset_retires", cnt, 3);
    iwait = 100;
    repeat (2) @(negedge clk);
    check("stall_pc", pc, 12'h003);
    check("stall_status", status, 4'h8);
    check("stall_req", imem_req, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("midfetch_reset_outputs", {imem_req, dmem_req, dmem_we, retire, halted}, 5'b0);
    @(posedge clk); #1 force_iack = 1'b1;
    @(negedge clk);
    check("late_ack_no_req", imem_req, 0);
    @(posedge clk); #1 reset = 1'b0;
    force_iack = 1'b0;
    iwait = 0;
    @(negedge clk);
    check("post_reset_pc", pc, 12'h000);
    check("post_reset_status", status, 4'h0);
    check("post_reset_fetch", {imem_req, imem_addr}, {1'b1, 12'h000});
    wait_halt("rstfetch", 200);
    finish_prog("rstfetch", 5, 4'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_cpu.md
MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 Parameter DATA_W, default 16, datapath/register width (>= 8).
REQ-002 Parameter REG_AW, default 4, register index width; register file has 2**REG_AW entries; INSTR_W = 4 + 3*REG_AW.
REQ-003 Parameter PC_W, default 12, program counter and memory address width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 imem_req / imem_addr  out  1 / PC_W  instruction fetch request; address = pc.
REQ-007 imem_ack / imem_rdata  in  1 / INSTR_W  fetch complete; rdata valid in the ack cycle.
REQ-008 dmem_req / dmem_we / dmem_addr  out  1 / 1 / PC_W  data request, write strobe, address.
REQ-009 dmem_wdata / dmem_rdata / dmem_ack  out DATA_W / in DATA_W / in 1  store data, load data, completion.
REQ-010 pc  out  PC_W  current program counter.
REQ-011 status  out  4  latched flags {N,V,C,Z}.
REQ-012 retire  out  1  one-cycle pulse per completed instruction.
REQ-013 halted  out  1  high while in HALT state.

Function
REQ-014 Instruction fields: op = [INSTR_W-1:INSTR_W-4], then s1, s2, d, each REG_AW bits, MSB to LSB.
REQ-015 Register 0 reads as 0; writes to register 0 are discarded.
REQ-016 FSM states FETCH, EXEC, MEM, HALT; exactly one active.
REQ-017 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on ack, IR<=imem_rdata, pc<=pc+1 mod 2**PC_W, go EXEC.
REQ-018 EXEC (one cycle): ops 0-8, B-E complete, assert retire, go FETCH; ops 9/A go MEM; op F goes HALT with retire.
REQ-019 0 NOP; 1 ADD; 2 SUB (a-b); 3 AND; 4 OR; 5 XOR; 6 SHL a by b[log2(DATA_W)-1:0]; 7 SHR logical, same amount; result to d, all mod 2**DATA_W.
REQ-020 8 LDI: d <= zero-extended {s2,s1} field concatenation ({IR fields s2 as high bits, s1 low}) truncated to DATA_W.
REQ-021 9 LD: dmem_addr=reg[s1][PC_W-1:0] (zero-extended if DATA_W<PC_W), d <= dmem_rdata on ack.
REQ-022 A ST: dmem_we=1, dmem_addr=reg[s1], dmem_wdata=reg[s2]; no register write.
REQ-023 B JMP: pc <= {s1,s2,d} zero-extended or truncated to PC_W.
REQ-024 C BZ / D BNZ / E BC: take JMP target if Z=1 / Z=0 / C=1, else pc unchanged (already incremented).
REQ-025 F HALT: enter HALT; remain until reset; no requests issued; halted=1.
REQ-026 Flags update only on ops 1-7, in EXEC: Z=(result==0), N=result MSB; ADD C=carry-out, V=signed overflow; SUB C=borrow (a<b unsigned), V=signed overflow; ops 3-7 C=0, V=0.
REQ-027 Branches read flags as latched before the branch's EXEC cycle.
REQ-028 MEM: dmem_req=1, address/we/wdata stable until dmem_ack; on ack, LD writes d, retire=1, go FETCH.
REQ-029 imem_req and dmem_req never high in the same cycle; each ack ignored when its req is low.
REQ-030 Ack in the first req cycle is legal (zero wait); any number of wait cycles is tolerated.
REQ-031 Instruction throughput: 2 cycles (ALU/branch) or 3 cycles (LD/ST) with zero-wait memories.

Reset
REQ-032 While reset=1: imem_req=0, dmem_req=0, dmem_we=0, retire=0, halted=0 in that same cycle.
REQ-033 On the reset edge: state<=FETCH, pc<=0, IR<=0, status<=0, all registers <=0.
REQ-034 Reset mid-fetch or mid-MEM abandons the transaction; no register, flag or pc update; late acks ignored.
REQ-035 First imem_req occurs in the first cycle with reset=0.

Verification
REQ-036 LDI r1,5; LDI r2,3; ADD r3=r1+r2 -> r3=8, status=0000, three retire pulses, zero-wait 6 cycles.
REQ-037 LDI r1,1; LDI r2,2; SUB r3=r1-r2 -> r3=0xFFFF, N=1, C=1, Z=0, V=0; then BC to 0x040 -> imem_addr=0x040.
REQ-038 LDI r1,0x7F then ADD chain to 0x7FFF + 1 -> result 0x8000, V=1, N=1; write to r0 -> r0 reads 0.
REQ-039 ST r1->[r2=0x10] with dmem_ack delayed 3 cycles -> req/addr/wdata stable 4 cycles, one retire; LD r4 from 0x10 -> r4=stored value.
REQ-040 JMP 0xFFF then fetch -> pc wraps to 0x000 after fetch; HALT -> halted=1, no further reqs; reset asserted mid-fetch with imem_ack next cycle -> pc=0, no IR load.
